axil_reg_slave: RTL and testbench

//  AXI-Lite slave register bank; terminates an AXIL_IF.Slave port downstream of the interconnect.

---
 rtl/axil_reg_slave_if.sv | 37 +++
 rtl/axil_reg_slave.sv | 129 ++++++++++++
 tb/tb_axil_reg_slave.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_reg_slave_if.sv
// AXI-Lite bus bundle (AW/W/B/AR/R) shared by the register slave and its master.
interface axil_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic                      awvalid;
  logic                      awready;
  logic [ADDR_WIDTH-1:0]     awaddr;
  logic [2:0]                awprot;
  logic                      wvalid;
  logic                      wready;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic                      bvalid;
  logic                      bready;
  logic [1:0]                bresp;
  logic                      arvalid;
  logic                      arready;
  logic [ADDR_WIDTH-1:0]     araddr;
  logic [2:0]                arprot;
  logic                      rvalid;
  logic                      rready;
  logic [DATA_WIDTH-1:0]     rdata;
  logic [1:0]                rresp;

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot,
           rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot,
           rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axil_reg_slave.sv
// AXI-Lite register bank: NUM_REGS byte-strobed RW registers, RO registers mirror hw_status.
// AW and W are buffered independently; a write commits the cycle after both are held.
module axil_reg_slave #(
  parameter int unsigned         ADDR_WIDTH = 12,
  parameter int unsigned         DATA_WIDTH = 32,
  parameter int unsigned         NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  axil_if.slave                          s_axil,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            reg_wr_pulse,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_status
);
  localparam int unsigned StrbWidth = DATA_WIDTH / 8;
  localparam int unsigned Ofs       = $clog2(StrbWidth);
  localparam int unsigned IdxWidth  = ADDR_WIDTH - Ofs;
  localparam logic [1:0]  RespOkay  = 2'b00;
  localparam logic [1:0]  RespSlvErr = 2'b10;

  logic                  rst_done_q;
  logic                  aw_held_q, w_held_q;
  logic [IdxWidth-1:0]   aw_idx_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [StrbWidth-1:0]  w_strb_q;
  logic                  bvalid_q, rvalid_q;
  logic [1:0]            bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [NUM_REGS-1:0]   pulse_q;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  logic                  awready, wready, arready;
  logic [IdxWidth-1:0]   ar_idx;
  logic                  aw_hit, ar_hit;
  logic [DATA_WIDTH-1:0] ar_data;
  logic                  unused_ok;

  assign awready = rst_done_q & ~aw_held_q & ~bvalid_q;
  assign wready  = rst_done_q & ~w_held_q & ~bvalid_q;
  assign arready = rst_done_q & ~rvalid_q;
  assign ar_idx  = s_axil.araddr[ADDR_WIDTH-1:Ofs];

  assign s_axil.awready = awready;
  assign s_axil.wready  = wready;
  assign s_axil.arready = arready;
  assign s_axil.bvalid  = bvalid_q;
  assign s_axil.bresp   = bresp_q;
  assign s_axil.rvalid  = rvalid_q;
  assign s_axil.rdata   = rdata_q;
  assign s_axil.rresp   = rresp_q;
  assign reg_wr_pulse   = pulse_q;

  assign unused_ok = ^{s_axil.awprot, s_axil.arprot, s_axil.awaddr[Ofs-1:0],
                       s_axil.araddr[Ofs-1:0]};

  // Address decode by comparison loop so the index never has to match the array width.
  always_comb begin
    aw_hit  = 1'b0;
    ar_hit  = 1'b0;
    ar_data = '0;
    reg_out = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
      if (aw_idx_q == IdxWidth'(i)) aw_hit = 1'b1;
      if (ar_idx == IdxWidth'(i)) begin
        ar_hit  = 1'b1;
        ar_data = RO_MASK[i] ? hw_status[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rst_done_q <= 1'b0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_idx_q   <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RespOkay;
      rvalid_q   <= 1'b0;
      rresp_q    <= RespOkay;
      rdata_q    <= '0;
      pulse_q    <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      rst_done_q <= 1'b1;
      pulse_q    <= '0;

      if (s_axil.awvalid && awready) begin
        aw_held_q <= 1'b1;
        aw_idx_q  <= s_axil.awaddr[ADDR_WIDTH-1:Ofs];
      end
      if (s_axil.wvalid && wready) begin
        w_held_q <= 1'b1;
        w_data_q <= s_axil.wdata;
        w_strb_q <= s_axil.wstrb;
      end

      if (aw_held_q && w_held_q) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= aw_hit ? RespOkay : RespSlvErr;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (aw_idx_q == IdxWidth'(i) && !RO_MASK[i]) begin
            pulse_q[i] <= 1'b1;
            for (int b = 0; b < StrbWidth; b++) begin
              if (w_strb_q[b]) regs_q[i][b*8 +: 8] <= w_data_q[b*8 +: 8];
            end
          end
        end
      end else if (bvalid_q && s_axil.bready) begin
        bvalid_q <= 1'b0;
      end

      // Read samples regs_q before any same-edge commit lands, so it returns the old value.
      if (s_axil.arvalid && arready) begin
        rvalid_q <= 1'b1;
        rdata_q  <= ar_hit ? ar_data : '0;
        rresp_q  <= ar_hit ? RespOkay : RespSlvErr;
      end else if (rvalid_q && s_axil.rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_axil_reg_slave.sv
// Randomised bench for axil_reg_slave against an array-based register model.
module tb_axil_reg_slave;
  localparam logic [15:0] RoMask = 16'h0008;

  logic         clk = 1'b0;
  logic         aresetn;
  logic [511:0] reg_out;
  logic [15:0]  reg_wr_pulse;
  logic [511:0] hw_status;

  int checks = 0;
  int failures = 0;

  logic [31:0] model_mem [16];
  logic [31:0] hw [16];

  axil_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();

  axil_reg_slave #(
    .ADDR_WIDTH(12), .DATA_WIDTH(32), .NUM_REGS(16), .RO_MASK(RoMask)
  ) dut (
    .aclk(clk), .aresetn(aresetn), .s_axil(bus), .reg_out(reg_out),
    .reg_wr_pulse(reg_wr_pulse), .hw_status(hw_status)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always_comb begin
    hw_status = '0;
    for (int i = 0; i < 16; i++) hw_status[i*32 +: 32] = hw[i];
  end

  function automatic logic [511:0] model_pack();
    logic [511:0] v = '0;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = model_mem[i];
    return v;
  endfunction

  // Expected effects of a write: response code and pulse mask; applies it to the model.
  function automatic void model_write(input logic [11:0] addr, input logic [31:0] data,
                                      input logic [3:0] strb, output logic [1:0] resp,
                                      output logic [15:0] pulse);
    int idx = int'(addr >> 2);
    pulse = '0;
    resp  = (idx < 16) ? 2'b00 : 2'b10;
    if (idx < 16 && !RoMask[idx]) begin
      pulse[idx] = 1'b1;
      for (int b = 0; b < 4; b++) if (strb[b]) model_mem[idx][b*8 +: 8] = data[b*8 +: 8];
    end
  endfunction

  function automatic void model_read(input logic [11:0] addr, output logic [31:0] data,
                                     output logic [1:0] resp);
    int idx = int'(addr >> 2);
    if (idx >= 16) begin
      data = '0; resp = 2'b10;
    end else begin
      data = RoMask[idx] ? hw[idx] : model_mem[idx]; resp = 2'b00;
    end
  endfunction

  task automatic do_write(input logic [11:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_dly, input int w_dly,
                          input int b_dly, output logic [1:0] resp, output int lat,
                          output logic [15:0] pulse_b, output logic [15:0] pulse_after,
                          output bit hold_err, output bit timeout);
    bit aw_done = 0, w_done = 0, aw_f, w_f;
    int cyc = 0;
    hold_err = 0; timeout = 0; lat = 0; resp = 2'bxx;
    pulse_b = 'x; pulse_after = 'x;
    bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
    while (!(aw_done && w_done) && cyc < 50) begin
      bus.awvalid = !aw_done && cyc >= aw_dly;
      bus.wvalid  = !w_done && cyc >= w_dly;
      if (aw_done && bus.awready) hold_err = 1;
      if (w_done && bus.wready) hold_err = 1;
      aw_f = bus.awvalid && bus.awready;
      w_f  = bus.wvalid && bus.wready;
      @(posedge clk); #1;
      aw_done |= aw_f; w_done |= w_f; cyc++;
    end
    bus.awvalid = 0; bus.wvalid = 0;
    if (!(aw_done && w_done)) timeout = 1;
    while (!bus.bvalid && lat < 20) begin @(posedge clk); #1; lat++; end
    if (!bus.bvalid) timeout = 1;
    if (!timeout) begin
      pulse_b = reg_wr_pulse;
      resp    = bus.bresp;
      for (int i = 0; i <= b_dly; i++) begin
        bus.bready = (i == b_dly);
        if (bus.bresp !== resp || bus.bvalid !== 1'b1 || bus.awready || bus.wready) hold_err = 1;
        @(posedge clk); #1;
        if (i == 0) pulse_after = reg_wr_pulse;
      end
      bus.bready = 0;
      if (bus.bvalid || !bus.awready || !bus.wready) hold_err = 1;
    end
  endtask

  task automatic do_read(input logic [11:0] addr, input int r_dly, output logic [31:0] data,
                         output logic [1:0] resp, output bit hold_err, output bit timeout);
    int cyc = 0;
    hold_err = 0; timeout = 0; data = 'x; resp = 'x;
    bus.araddr = addr; bus.arvalid = 1;
    while (!bus.arready && cyc < 20) begin @(posedge clk); #1; cyc++; end
    if (!bus.arready) begin
      timeout = 1; bus.arvalid = 0;
    end else begin
      @(posedge clk); #1;
      bus.arvalid = 0;
      if (!bus.rvalid) timeout = 1;
      data = bus.rdata; resp = bus.rresp;
      for (int i = 0; i <= r_dly; i++) begin
        bus.rready = (i == r_dly);
        if (bus.rdata !== data || bus.rresp !== resp || !bus.rvalid || bus.arready) hold_err = 1;
        @(posedge clk); #1;
      end
      bus.rready = 0;
      if (bus.rvalid) hold_err = 1;
    end
  endtask

  task automatic test_reset();
    aresetn = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs got %b exp 00000",
               {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid});
    end
    checks++;
    if (reg_out !== '0 || reg_wr_pulse !== '0) begin
      failures++; $display("FAIL reset_regs got %h exp 0", reg_out);
    end
    aresetn = 1;
    #1;
    checks++;
    if ({bus.awready, bus.wready, bus.arready} !== 3'b000) begin
      failures++;
      $display("FAIL ready_first_cycle got %b exp 000", {bus.awready, bus.wready, bus.arready});
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
      failures++;
      $display("FAIL ready_after_rst got %b exp 111", {bus.awready, bus.wready, bus.arready});
    end
  endtask

  task automatic test_write_read();
    logic [1:0] resp, eresp; logic [15:0] pb, pa, ep; logic [31:0] rd, ed;
    int lat; bit herr, to;
    model_write(12'h008, 32'hDEADBEEF, 4'hF, eresp, ep);
    do_write(12'h008, 32'hDEADBEEF, 4'hF, 0, 0, 0, resp, lat, pb, pa, herr, to);
    checks++;
    if (to || lat != 1 || resp !== eresp) begin
      failures++; $display("FAIL wr_basic lat=%0d resp=%b to=%0d exp lat=1 resp=%b", lat, resp,
                           to, eresp);
    end
    checks++;
    if (pb !== ep || pa !== 16'h0) begin
      failures++; $display("FAIL wr_pulse got %h/%h exp %h/0000", pb, pa, ep);
    end
    model_read(12'h008, ed, eresp);
    do_read(12'h008, 0, rd, resp, herr, to);
    checks++;
    if (to || rd !== ed || resp !== eresp) begin
      failures++; $display("FAIL rd_basic got %h/%b exp %h/%b", rd, resp, ed, eresp);
    end
  endtask

  task automatic test_order_strobe();
    logic [1:0] resp, eresp; logic [15:0] pb, pa, ep;
    int lat; bit herr, to;
    model_write(12'h004, 32'hAABBCCDD, 4'hF, eresp, ep);
    do_write(12'h004, 32'hAABBCCDD, 4'hF, 0, 0, 0, resp, lat, pb, pa, herr, to);
    model_write(12'h004, 32'h11223344, 4'b0101, eresp, ep);
    do_write(12'h004, 32'h11223344, 4'b0101, 3, 0, 2, resp, lat, pb, pa, herr, to);
    checks++;
    if (reg_out[32 +: 32] !== 32'hAA22CC44 || reg_out !== model_pack()) begin
      failures++; $display("FAIL strobe_merge got %h exp AA22CC44", reg_out[32 +: 32]);
    end
    checks++;
    if (herr || to || lat != 1 || pb !== ep) begin
      failures++; $display("FAIL w_before_aw herr=%0d to=%0d lat=%0d pulse=%h exp 0/0/1/%h",
                           herr, to, lat, pb, ep);
    end
    model_write(12'h018, 32'h0BAD_F00D, 4'h0, eresp, ep);
    do_write(12'h01A, 32'h0BAD_F00D, 4'h0, 0, 2, 0, resp, lat, pb, pa, herr, to);
    checks++;
    if (pb !== ep || reg_out !== model_pack() || herr || to) begin
      failures++; $display("FAIL zero_strb pulse=%h exp %h", pb, ep);
    end
  endtask

  task automatic test_errors_ro();
    logic [1:0] resp, eresp; logic [15:0] pb, pa, ep; logic [31:0] rd, ed;
    int lat; bit herr, to;
    model_write(12'h040, 32'h12345678, 4'hF, eresp, ep);
    do_write(12'h040, 32'h12345678, 4'hF, 0, 0, 0, resp, lat, pb, pa, herr, to);
    checks++;
    if (resp !== 2'b10 || pb !== 16'h0 || reg_out !== model_pack() || to) begin
      failures++; $display("FAIL wr_oor resp=%b pulse=%h exp 10/0000", resp, pb);
    end
    hw[3] = 32'h0000_5A5A;
    model_write(12'h00C, 32'hFFFF_FFFF, 4'hF, eresp, ep);
    do_write(12'h00C, 32'hFFFF_FFFF, 4'hF, 1, 0, 0, resp, lat, pb, pa, herr, to);
    checks++;
    if (resp !== 2'b00 || pb !== 16'h0 || reg_out[96 +: 32] !== 32'h0 || to) begin
      failures++; $display("FAIL wr_ro resp=%b pulse=%h reg=%h exp 00/0000/0", resp, pb,
                           reg_out[96 +: 32]);
    end
    do_read(12'h00C, 0, rd, resp, herr, to);
    checks++;
    if (rd !== 32'h5A5A || resp !== 2'b00 || to) begin
      failures++; $display("FAIL rd_ro got %h/%b exp 00005a5a/00", rd, resp);
    end
    do_read(12'h040, 0, rd, resp, herr, to);
    checks++;
    if (rd !== 32'h0 || resp !== 2'b10 || to) begin
      failures++; $display("FAIL rd_oor got %h/%b exp 0/10", rd, resp);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] resp, eresp; logic [15:0] pb, pa, ep; logic [31:0] rd, ed, oldv, newv;
    int lat; bit herr, to;
    model_write(12'h028, 32'hCAFE_0001, 4'hF, eresp, ep);
    do_write(12'h028, 32'hCAFE_0001, 4'hF, 0, 0, 5, resp, lat, pb, pa, herr, to);
    checks++;
    if (herr || to || resp !== eresp) begin
      failures++; $display("FAIL b_backpressure herr=%0d to=%0d resp=%b exp 0/0/%b", herr, to,
                           resp, eresp);
    end
    model_read(12'h028, ed, eresp);
    do_read(12'h028, 5, rd, resp, herr, to);
    checks++;
    if (herr || to || rd !== ed) begin
      failures++; $display("FAIL r_backpressure herr=%0d rd=%h exp 0/%h", herr, rd, ed);
    end
    // Commit and AR handshake land on the same edge.
    oldv = model_mem[2];
    newv = $urandom;
    bus.awaddr = 12'h008; bus.wdata = newv; bus.wstrb = 4'hF;
    bus.awvalid = 1; bus.wvalid = 1;
    @(posedge clk); #1;
    bus.awvalid = 0; bus.wvalid = 0;
    bus.araddr = 12'h008; bus.arvalid = 1;
    @(posedge clk); #1;
    bus.arvalid = 0;
    model_write(12'h008, newv, 4'hF, eresp, ep);
    checks++;
    if (bus.bvalid !== 1'b1 || bus.rvalid !== 1'b1 || bus.rdata !== oldv) begin
      failures++; $display("FAIL collision bvalid=%b rvalid=%b rdata=%h exp 1/1/%h",
                           bus.bvalid, bus.rvalid, bus.rdata, oldv);
    end
    checks++;
    if (reg_out !== model_pack()) begin
      failures++; $display("FAIL collision_reg got %h exp %h", reg_out[64 +: 32], newv);
    end
    bus.bready = 1; bus.rready = 1;
    @(posedge clk); #1;
    bus.bready = 0; bus.rready = 0;
  endtask

  task automatic test_random();
    logic [1:0] resp, eresp; logic [15:0] pb, pa, ep; logic [31:0] rd, ed, data;
    logic [11:0] addr; logic [3:0] strb;
    int lat; bit herr, to;
    for (int n = 0; n < 40; n++) begin
      addr = 12'(($urandom_range(0, 17) << 2) | $urandom_range(0, 3));
      hw[3] = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        data = $urandom; strb = 4'($urandom_range(0, 15));
        model_write(addr, data, strb, eresp, ep);
        do_write(addr, data, strb, $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 2), resp, lat, pb, pa, herr, to);
        checks++;
        if (to || herr || lat != 1 || resp !== eresp || pb !== ep || pa !== 16'h0 ||
            reg_out !== model_pack()) begin
          failures++;
          $display("FAIL rand_wr a=%h resp=%b pulse=%h lat=%0d herr=%0d exp resp=%b pulse=%h",
                   addr, resp, pb, lat, herr, eresp, ep);
        end
      end else begin
        model_read(addr, ed, eresp);
        do_read(addr, $urandom_range(0, 2), rd, resp, herr, to);
        checks++;
        if (to || herr || rd !== ed || resp !== eresp) begin
          failures++;
          $display("FAIL rand_rd a=%h got %h/%b exp %h/%b", addr, rd, resp, ed, eresp);
        end
      end
    end
  endtask

  task automatic test_reset_dirty();
    logic [1:0] resp, eresp; logic [15:0] pb, pa, ep; logic [31:0] rd, ed;
    int lat; bit herr, to;
    // Leave an AW held and an R response pending, then reset mid-cycle.
    bus.awaddr = 12'h014; bus.awvalid = 1;
    bus.araddr = 12'h008; bus.arvalid = 1;
    @(posedge clk); #1;
    bus.awvalid = 0; bus.arvalid = 0;
    #2 aresetn = 0;
    #1;
    for (int i = 0; i < 16; i++) model_mem[i] = '0;
    checks++;
    if (reg_out !== '0 || bus.bvalid !== 1'b0 || bus.rvalid !== 1'b0 || bus.awready !== 1'b0) begin
      failures++; $display("FAIL async_reset reg_or=%b rvalid=%b awready=%b exp 0/0/0",
                           |reg_out, bus.rvalid, bus.awready);
    end
    @(posedge clk); #1;
    aresetn = 1;
    @(posedge clk); #1;
    model_write(12'h01C, 32'h7777_1234, 4'hF, eresp, ep);
    do_write(12'h01C, 32'h7777_1234, 4'hF, 4, 0, 0, resp, lat, pb, pa, herr, to);
    checks++;
    if (to || herr || lat != 1 || pb !== ep || reg_out !== model_pack()) begin
      failures++; $display("FAIL post_reset_wr to=%0d herr=%0d lat=%0d pulse=%h exp 0/0/1/%h",
                           to, herr, lat, pb, ep);
    end
    model_read(12'h008, ed, eresp);
    do_read(12'h008, 0, rd, resp, herr, to);
    checks++;
    if (to || rd !== ed || resp !== eresp) begin
      failures++; $display("FAIL post_reset_rd got %h exp %h", rd, ed);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin model_mem[i] = '0; hw[i] = 32'($urandom); end
    bus.awvalid = 0; bus.awaddr = '0; bus.awprot = '0;
    bus.wvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.bready = 0;
    bus.arvalid = 0; bus.araddr = '0; bus.arprot = '0; bus.rready = 0;
    aresetn = 0;
    #1;
    test_reset();
    test_write_read();
    test_order_strobe();
    test_errors_ro();
    test_backpressure();
    test_random();
    test_reset_dirty();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
